// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue sequencer in front of a registered ALU.
// Commands are queued, presented one at a time on alu_a/alu_b/alu_p, held for
// the ALU latency, and the captured result is returned on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int unsigned DW      = 2,
  parameter int unsigned OPW     = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_a,
  input  logic [DW-1:0]            in_b,
  input  logic [OPW-1:0]           in_op,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [OPW-1:0]           alu_p,
  input  logic [DW-1:0]            alu_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_c,
  output logic [OPW-1:0]           out_op,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned EW = OPW + 2 * DW;
  localparam int unsigned CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  logic [EW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic [LW-1:0]  level_d;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [OPW-1:0] tag_q;
  logic [DW-1:0]  alu_a_q;
  logic [DW-1:0]  alu_b_q;
  logic [OPW-1:0] alu_p_q;
  logic           out_valid_q;
  logic [DW-1:0]  out_c_q;
  logic [OPW-1:0] out_op_q;

  logic           push;
  logic           pop;
  logic [OPW-1:0] head_op;
  logic [DW-1:0]  head_a;
  logic [DW-1:0]  head_b;

  // Full is judged on the registered level only, so a same-cycle pop never
  // opens room for a push.
  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign {head_op, head_a, head_b} = mem_q[rd_ptr_q];

  // Load event: pop the FIFO head whenever the sequencer is free for a new command.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      IDLE:    pop = (level_q != '0);
      DONE:    pop = out_ready && (level_q != '0);
      default: pop = 1'b0;
    endcase
  end

  // Occupancy update from the push/pop pair.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; entries need no reset since level marks them invalid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= {in_op, in_a, in_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  // Issue FSM: load, hold for the ALU latency plus one cycle, capture, hand off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tag_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_p_q     <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_op_q    <= '0;
    end else begin
      if (pop) begin
        alu_a_q <= head_a;
        alu_b_q <= head_b;
        alu_p_q <= head_op;
        tag_q   <= head_op;
        cnt_q   <= '0;
      end
      unique case (state_q)
        IDLE: begin
          if (pop) state_q <= EXEC;
        end
        EXEC: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(ALU_LAT)) begin
            out_c_q     <= alu_c;
            out_op_q    <= tag_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= pop ? EXEC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_p     = alu_p_q;
  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_op    = out_op_q;
  assign level     = level_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a registered (a+b) ALU stub.
module tb_alu_cmd_sequencer;

  localparam int DW      = 2;
  localparam int OPW     = 3;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic [OPW-1:0] in_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_p;
  logic [DW-1:0]  alu_c;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_c;
  logic [OPW-1:0] out_op;
  logic [$clog2(DEPTH):0] level;
  logic           busy;

  typedef struct {
    int c;
    int op;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   saw_block = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DW(DW), .OPW(OPW), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_p(alu_p), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_op(out_op),
    .level(level), .busy(busy)
  );

  // ALU stub: one register stage, c = (a + b) mod 2**DW
  always_ff @(posedge clk) alu_c <= alu_a + alu_b;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_c(input int a, input int b);
    return (a + b) % (1 << DW);
  endfunction

  // Monitor/scoreboard: compares the held result against the oldest expected
  // entry every cycle it is presented, and records accepted commands.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("out_c", int'(out_c), exp_q[0].c);
          chk("out_op", int'(out_op), exp_q[0].op);
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_cyc.push_back(cyc);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.c  = ref_c(int'(in_a), int'(in_b));
        e.op = int'(in_op);
        exp_q.push_back(e);
      end
      chk("in_ready_vs_level", int'(in_ready), int'(level != DEPTH));
      if (in_valid && !in_ready) saw_block = 1'b1;
    end
  end

  task automatic push(input int a, input int b, input int op);
    int n;
    bit acc;
    in_a     = DW'(a);
    in_b     = DW'(b);
    in_op    = OPW'(op);
    in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("push_accept", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", int'(exp_q.size() == 0 && !busy), 1);
  endtask

  // Random stream: wrap pattern uses a=i mod 4, b=3; otherwise all fields random.
  task automatic run_stream(input int n, input bit wrap_pattern);
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          if (wrap_pattern) push(i % 4, 3, $urandom_range(0, 7));
          else push($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_drain(400);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single command: push on E0, load on E1, result after E3.
    push(2, 1, 0);
    chk("single_e0_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("single_e1_alu_a", int'(alu_a), 2);
    chk("single_e1_alu_b", int'(alu_b), 1);
    chk("single_e1_alu_p", int'(alu_p), 0);
    chk("single_e1_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("single_e2_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("single_e3_valid", int'(out_valid), 1);
    chk("single_e3_c", int'(out_c), 3);
    chk("single_e3_op", int'(out_op), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("single_busy_fall", int'(busy), 0);
    chk("single_valid_fall", int'(out_valid), 0);

    // Opcode sweep back-to-back, results every ALU_LAT+2 cycles.
    hs_cyc.delete();
    saw_block = 1'b0;
    for (int i = 0; i < 8; i++) push(2, 1, i);
    wait_drain(200);
    chk("sweep_blocked_when_full", int'(saw_block), 1);
    chk("sweep_count", hs_cyc.size(), 8);
    for (int i = 1; i < hs_cyc.size(); i++) chk("sweep_spacing", hs_cyc[i] - hs_cyc[i-1], ALU_LAT + 2);

    // Output stall fills the FIFO; then a full-FIFO push coincides with a pop.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push($urandom_range(0, 3), $urandom_range(0, 3), i);
    repeat (2) begin @(posedge clk); #1; end
    chk("stall_level", int'(level), DEPTH);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_valid", int'(out_valid), 1);
    in_a = 2'd1; in_b = 2'd1; in_op = 3'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_pop_level", int'(level), DEPTH - 1);
    wait_drain(200);

    // Reset while one command executes and three are queued.
    for (int i = 0; i < 5; i++) push(2, 1, i + 1);
    chk("pre_rst_level", int'(level), 3);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_valid", int'(out_valid), 0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_alu_a", int'(alu_a), 0);
    chk("rst_mid_alu_b", int'(alu_b), 0);
    chk("rst_mid_alu_p", int'(alu_p), 0);
    chk("rst_mid_out_c", int'(out_c), 0);
    chk("rst_mid_out_op", int'(out_op), 0);
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_level", int'(level), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push(1, 1, 3);
    wait_drain(50);

    // Pointer wrap with random back-pressure, then a fully random stream.
    run_stream(11, 1'b1);
    run_stream(40, 1'b0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
